// File: rtl/mem_burst_master.sv
// mem_burst_master: accepts single/burst read and write requests on a simple
// request/handshake interface and turns them into fixed-address burst cycles on
// a pipelined memory port (the memory advances the word address internally).
//
// Ports:
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   req_valid/req_ready       request handshake; req_addr, req_wr, req_size
//   wdata/wdata_valid/ready   write word stream (one word per accepted cycle)
//   rdata/valid/last          read word stream, no backpressure
//   done, err                 one-cycle completion / rejection pulses
//   mem_*                     memory command, write data, read data and busy
module mem_burst_master #(
  parameter int unsigned RD_LAT    = 2,
  parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        rdata_last,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  mem_acc_size,
  output logic        mem_wren,
  output logic        mem_enable,
  input  logic        mem_busy
);

  typedef enum logic [2:0] {IDLE, WFILL, WAIT_MEM, WBURST, RCMD, RDATA, FIN} state_t;

  localparam logic [7:0] LAT = 8'(RD_LAT);

  function automatic logic [4:0] burst_len(input logic [1:0] sz);
    case (sz)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic [4:0]  cnt;
  logic [7:0]  lat_cnt;
  logic        rd_drain;
  logic [31:0] data_hold;
  logic [31:0] wbuf [16];

  logic [4:0]  req_len;
  logic [32:0] req_end;
  logic [32:0] win_end;
  logic        addr_ok;
  logic [4:0]  n_last;
  logic        rd_window;
  logic        sample;
  logic        last_word;

  // 33-bit sums so a burst ending exactly at the top of the 4 GiB space still compares correctly
  assign req_len   = burst_len(req_size);
  assign req_end   = {1'b0, req_addr} + {26'b0, req_len, 2'b00};
  assign win_end   = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};
  assign addr_ok   = (req_addr[1:0] == 2'b00) && (req_addr >= MEM_BASE) && (req_end <= win_end);

  assign n_last    = burst_len(size_q) - 5'd1;
  // rd_drain marks the single cycle after the last sample, where rdata_last is shown
  // and the memory command is already released
  assign rd_window = (state == RCMD) || ((state == RDATA) && !rd_drain);
  assign sample    = rd_window && (lat_cnt >= LAT);
  assign last_word = (cnt == n_last);

  assign req_ready    = (state == IDLE);
  assign wdata_ready  = (state == WFILL);
  assign done         = (state == FIN);
  assign mem_enable   = (state == WBURST) || rd_window;
  assign mem_wren     = (state == WBURST);
  assign mem_addr     = addr_q;
  assign mem_acc_size = size_q;
  assign mem_data_in  = (state == WBURST) ? wbuf[cnt[3:0]] : data_hold;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_valid) state_n = !addr_ok ? IDLE : (req_wr ? WFILL : WAIT_MEM);
      WFILL:    if (wdata_valid && last_word) state_n = WAIT_MEM;
      WAIT_MEM: if (!mem_busy) state_n = wr_q ? WBURST : RCMD;
      WBURST:   if (last_word) state_n = FIN;
      RCMD:     state_n = RDATA;
      RDATA:    if (rd_drain) state_n = FIN;
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == WFILL && wdata_valid) wbuf[cnt[3:0]] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q      <= '0;
      size_q      <= '0;
      wr_q        <= 1'b0;
      cnt         <= '0;
      lat_cnt     <= '0;
      rd_drain    <= 1'b0;
      data_hold   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      err         <= 1'b0;
    end else begin
      err         <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            addr_q <= req_addr;
            wr_q   <= req_wr;
            size_q <= req_size;
            err    <= !addr_ok;
          end
        end
        WFILL: if (wdata_valid) cnt <= cnt + 5'd1;
        WAIT_MEM: begin
          cnt      <= '0;
          lat_cnt  <= '0;
          rd_drain <= 1'b0;
        end
        WBURST: begin
          data_hold <= wbuf[cnt[3:0]];
          cnt       <= cnt + 5'd1;
        end
        RCMD, RDATA: begin
          if (lat_cnt < LAT) lat_cnt <= lat_cnt + 8'd1;
          if (sample) begin
            rdata       <= mem_data_out;
            rdata_valid <= 1'b1;
            rdata_last  <= last_word;
            cnt         <= cnt + 5'd1;
            if (last_word) rd_drain <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning cycles from read-command cycle to first valid mem_data_out word.
REQ-002 SHALL have parameter MEM_BASE, default 32'h80020000, meaning lowest legal byte address.
REQ-003 SHALL have parameter MEM_BYTES, default 32'h0010_0000, meaning size of legal address window in bytes.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: req_valid in 1 request strobe; req_ready out 1 block can accept; req_addr in 32 byte address; req_wr in 1 1=write 0=read; req_size in 2 burst code.
REQ-006 SHALL have ports: wdata in 32 write word; wdata_valid in 1 write word strobe; wdata_ready out 1 block accepts write word.
REQ-007 SHALL have ports: rdata out 32 read word; rdata_valid out 1 read word strobe; rdata_last out 1 final word of burst; done out 1 request complete pulse; err out 1 request rejected pulse.
REQ-008 SHALL have memory-side ports: mem_addr out 32; mem_data_in out 32 (to memory data_in); mem_data_out in 32 (from memory); mem_acc_size out 2; mem_wren out 1; mem_enable out 1; mem_busy in 1.

Function
REQ-009 SHALL map req_size/mem_acc_size 00,01,10,11 to burst length N = 1,4,8,16 words.
REQ-010 SHALL implement states IDLE, WFILL, WAIT_MEM, WBURST, RCMD, RDATA, FIN.
REQ-011 SHALL assert req_ready only in IDLE; request accepted on req_valid & req_ready; addr, wr, size latched on acceptance.
REQ-012 SHALL reject requests with req_addr[1:0]!=0, or req_addr<MEM_BASE, or req_addr+4N>MEM_BASE+MEM_BYTES: err pulses 1 cycle after acceptance, no mem_enable, return to IDLE.
REQ-013 Write: WFILL SHALL assert wdata_ready and store words in a 16x32 buffer, one per wdata_valid cycle; gaps allowed; after N words go to WAIT_MEM.
REQ-014 WAIT_MEM SHALL hold mem_enable=0 while mem_busy=1; leave on first cycle mem_busy=0 to WBURST (write) or RCMD (read).
REQ-015 WBURST SHALL drive N consecutive cycles with mem_enable=1, mem_wren=1, mem_addr=latched addr, mem_acc_size=latched size, mem_data_in=buffer word k in cycle k (k=0..N-1); no gaps.
REQ-016 Read: after acceptance SHALL go directly to WAIT_MEM; RCMD SHALL drive one cycle mem_enable=1, mem_wren=0, mem_addr, mem_acc_size.
REQ-017 mem_enable SHALL remain 1, mem_wren 0, mem_addr/mem_acc_size held, from RCMD through the cycle the last word is sampled.
REQ-018 SHALL sample mem_data_out at RD_LAT, RD_LAT+1, ..., RD_LAT+N-1 cycles after the RCMD cycle; each sample presented on rdata with rdata_valid=1 one cycle later; rdata_last=1 with word N-1.
REQ-019 rdata has no backpressure; consumer SHALL accept every rdata_valid word.
REQ-020 mem_busy SHALL be ignored once a burst has started.
REQ-021 FIN SHALL pulse done for 1 cycle (after last write cycle or with cycle after rdata_last) then return to IDLE; next request acceptable the following cycle.
REQ-022 Outside WBURST/RCMD/RDATA mem_enable=0 and mem_wren=0; mem_data_in SHALL hold its last value.

Reset
REQ-023 On clock edge with reset_n=0 SHALL enter IDLE: req_ready=1 (after release), wdata_ready=0, rdata=0, rdata_valid=0, rdata_last=0, done=0, err=0, mem_enable=0, mem_wren=0, mem_addr=0, mem_data_in=0, mem_acc_size=00.
REQ-024 Reset mid-burst SHALL abort immediately: mem_enable=0 on the cycle after the reset edge, buffer contents discarded, no done pulse.

Verification
REQ-025 Single write 0x55cc55cc to 0x80020000, then single read -> one mem_enable/mem_wren cycle, then rdata=0x55cc55cc, rdata_valid and rdata_last 1 cycle, done pulses.
REQ-026 4-word write at 0x80020004 of 55cc55cd,55cc55ce,55cc55cf,55cc55c1 with a 2-cycle wdata_valid gap -> 4 contiguous mem write cycles; 4-word read at 0x80020004 returns same words in order, rdata_last on 4th.
REQ-027 Request at 0x80020002 and at 0x7FFFFFFC -> err pulse each, mem_enable never asserted, req_ready back next cycle.
REQ-028 mem_busy held 1 for 3 cycles at read start -> RCMD delayed exactly 3 cycles; data latency RD_LAT unchanged after RCMD.
REQ-029 16-word read at 0x80020000 with reset_n low at word 5 -> rdata_valid stops, mem_enable 0 next cycle, no done, subsequent single read correct.
